pixie_dma_arbiter: RTL and testbench
====================================

// Module: pixie_dma_arbiter
// PURPOSE
//  Shares the single system RAM port between the CDP1802 CPU and the Pixie (CDP1861) display DMA.
//  Sits between the CPU bus, the pixie_video DMA interface (DMAO / data_addr / data_in / data_ack) and the RAM.
//  Sequences each access as a 2-phase request/return, gives DMA priority and enforces a CPU-starvation cap.
//  Drives SC=S2 during DMA cycles and counts DMA bytes per frame for debug.
// PARAMETERS
//  DMA_BURST_MAX  8   max consecutive DMA grants while CPU is pending; 0 = no cap (DMA always wins)
//  ADDR_W         16  RAM address width
// PORTS
//  clk          in   1       system clock (CDP1802 bus clock domain)
//  reset        in   1       synchronous, active-low reset (asserted when 0)
//  clk_enable   in   1       bus-cycle enable; all state advances only when 1
//  cpu_req      in   1       CPU access request, held until cpu_ack
//  cpu_we       in   1       CPU write (1) / read (0)
//  cpu_addr     in   ADDR_W  CPU address
//  cpu_wdata    in   8       CPU write data
//  cpu_sc       in   2       CPU state code (S0..S3)
//  cpu_rdata    out  8       CPU read data, valid with cpu_ack
//  cpu_ack      out  1       one-clk pulse: CPU access complete
//  dma_req      in   1       DMA request (pixie DMAO), held until dma_ack
//  dma_addr     in   ADDR_W  DMA address (pixie data_addr)
//  dma_data     out  8       DMA read data to pixie data_in, valid with dma_ack
//  dma_ack      out  1       one-clk pulse: DMA byte delivered (pixie data_ack)
//  frame_start  in   1       one-clk pulse at start of frame; clears byte counter
//  sc_out       out  2       state code to pixie SC: 2'b10 during DMA, else cpu_sc
//  frame_bytes  out  11      DMA bytes delivered in previous frame (saturating)
//  mem_en       out  1       RAM enable
//  mem_we       out  1       RAM write enable
//  mem_addr     out  ADDR_W  RAM address
//  mem_wdata    out  8       RAM write data
//  mem_rdata    in   8       RAM read data, 1 clk latency after mem_en
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=IDLE; mem_en, mem_we, cpu_ack, dma_ack=0; mem_addr, mem_wdata, cpu_rdata,
//   dma_data=0; burst_cnt=0; byte_cnt=0; frame_bytes=0; sc_out=cpu_sc. Reset mid-access abandons it; no ack is issued.
//  FSM states: IDLE, DMA_ACC, DMA_RET, CPU_ACC, CPU_RET. Transitions occur only on clk_enable=1.
//  IDLE: dma_req & !(cap_hit & cpu_req) -> DMA_ACC; else cpu_req -> CPU_ACC; else stay.
//   cap_hit = (DMA_BURST_MAX!=0) & (burst_cnt==DMA_BURST_MAX).
//  DMA_ACC: mem_en=1, mem_we=0, mem_addr=dma_addr registered on entry; sc_out=2'b10; -> DMA_RET.
//  DMA_RET: dma_data<=mem_rdata; dma_ack pulses 1 clk; sc_out stays 2'b10; -> IDLE.
//   burst_cnt+1 if cpu_req was high at grant, else burst_cnt=0. byte_cnt+1, saturating at 2047.
//  CPU_ACC: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata registered on entry; -> CPU_RET.
//  CPU_RET: if read, cpu_rdata<=mem_rdata; cpu_ack pulses 1 clk; burst_cnt=0; -> IDLE.
//  mem_en/mem_we deassert in *_RET and IDLE. Latency: grant to ack = 2 enabled cycles; 1 idle turnaround each.
//  Simultaneous cpu_req & dma_req in IDLE: DMA wins unless cap_hit, then CPU wins once.
//  Requests are sampled only in IDLE; dropping a request while its access is in flight still completes it.
//  clk_enable=0 freezes state and registered outputs; ack pulses are issued only on enabled edges.
//  frame_start: frame_bytes<=byte_cnt (plus 1 if a DMA ack occurs on the same edge); byte_cnt<=0,
//   or <=1 if a DMA ack occurs on the same edge. frame_start has priority over saturation.
// TESTING
//  Reset: hold reset=0 for 3 clks -> all outputs 0, sc_out==cpu_sc, no mem_en.
//  CPU read 0x0123 (RAM=0x5A), clk_enable=1 -> mem_en 1 clk; cpu_ack with cpu_rdata=0x5A on the 2nd edge after grant.
//  Pixie line of 8 DMA reads from 0x0900..0x0907, no CPU -> 8 dma_acks, sc_out=2'b10 only in DMA_ACC/DMA_RET.
//  CPU held pending through 20 DMA requests, DMA_BURST_MAX=8 -> exactly 1 CPU access after every 8th DMA.
//  Simultaneous first requests -> DMA first, CPU next; clk_enable toggled 1/0 -> identical sequence, stretched.
//  1024 DMA bytes then frame_start -> frame_bytes=1024; reset asserted in DMA_ACC -> no dma_ack, state IDLE.

Source files
------------

// File: rtl/pixie_dma_arbiter.sv
// ---------------------------------------------------------------------------
// pixie_dma_arbiter
//
// Shares the single system RAM port between the CDP1802 CPU and the Pixie
// (CDP1861) display DMA. Every access is a two-phase request/return:
//   *_ACC drives the RAM for one enabled cycle.
//   *_RET captures the RAM read data (one clock of RAM latency) and raises
//   the matching ack.
// DMA normally wins. After DMA_BURST_MAX consecutive DMA grants taken while
// the CPU was waiting, the CPU is given one access. Also counts the DMA bytes
// delivered per frame, for debug.
//
// Ports
//   clk, reset     bus clock; synchronous active-low reset
//   clk_enable     bus-cycle enable; state advances only when 1
//   cpu_*          CPU request/ack handshake, address, data and state code
//   dma_*          pixie DMA request/ack handshake, address and read data
//   frame_start    start-of-frame pulse; latches and clears the byte count
//   sc_out         state code to the pixie (S2 during DMA cycles)
//   frame_bytes    DMA bytes delivered in the previous frame (saturating)
//   mem_*          synchronous RAM port with 1-clock read latency
// ---------------------------------------------------------------------------
module pixie_dma_arbiter #(
  parameter int DMA_BURST_MAX = 8,
  parameter int ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic [1:0]        cpu_sc,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic [7:0]        dma_data,
  output logic              dma_ack,
  input  logic              frame_start,
  output logic [1:0]        sc_out,
  output logic [10:0]       frame_bytes,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DMA_ACC = 3'd1,
    DMA_RET = 3'd2,
    CPU_ACC = 3'd3,
    CPU_RET = 3'd4
  } state_t;

  // The burst counter only has to reach DMA_BURST_MAX. With the cap disabled
  // (0), it still counts but saturates and is never compared.
  localparam int BW = (DMA_BURST_MAX < 2) ? 1 : $clog2(DMA_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_CAP = BW'(DMA_BURST_MAX);
  localparam logic [BW-1:0] BURST_SAT = {BW{1'b1}};
  localparam logic [10:0]   BYTE_SAT  = 11'h7FF;

  state_t          state;
  state_t          state_next;
  logic [BW-1:0]   burst_cnt;
  logic            cap_hit;
  logic            cpu_pend_at_grant;
  logic            cpu_we_q;
  logic [10:0]     byte_cnt;
  logic            dma_done;
  logic [10:0]     byte_cnt_inc;

  assign cap_hit  = (DMA_BURST_MAX != 0) && (burst_cnt == BURST_CAP);
  assign dma_done = (state == DMA_RET);
  assign byte_cnt_inc = (byte_cnt == BYTE_SAT) ? BYTE_SAT : byte_cnt + 11'd1;

  // State register. A reset in the middle of an access simply abandons it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else if (clk_enable) begin
      state <= state_next;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, so a request that
  // is dropped while its access is in flight still runs to completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dma_req && !(cap_hit && cpu_req)) begin
          state_next = DMA_ACC;
        end else if (cpu_req) begin
          state_next = CPU_ACC;
        end
      end
      DMA_ACC: state_next = DMA_RET;
      DMA_RET: state_next = IDLE;
      CPU_ACC: state_next = CPU_RET;
      CPU_RET: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. The pixie sees S2 for the whole DMA access and the CPU
  // state code at all other times.
  always_comb begin
    sc_out = cpu_sc;
    if ((state == DMA_ACC) || (state == DMA_RET)) begin
      sc_out = 2'b10;
    end
  end

  // RAM port, return data, acks and burst counter.
  // The RAM strobes are loaded on the grant edge and dropped on the edge
  // that leaves *_ACC.
  // The acks are cleared on every clock edge, including edges where
  // clk_enable is 0, so each ack is exactly one clock wide. They are only
  // raised on enabled edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_en            <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      cpu_rdata         <= '0;
      dma_data          <= '0;
      cpu_ack           <= 1'b0;
      dma_ack           <= 1'b0;
      burst_cnt         <= '0;
      cpu_pend_at_grant <= 1'b0;
      cpu_we_q          <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      if (clk_enable) begin
        case (state)
          IDLE: begin
            if (state_next == DMA_ACC) begin
              mem_en            <= 1'b1;
              mem_we            <= 1'b0;
              mem_addr          <= dma_addr;
              cpu_pend_at_grant <= cpu_req;
            end else if (state_next == CPU_ACC) begin
              mem_en    <= 1'b1;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              cpu_we_q  <= cpu_we;
            end
          end
          DMA_ACC, CPU_ACC: begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end
          DMA_RET: begin
            dma_data <= mem_rdata;
            dma_ack  <= 1'b1;
            // Only grants that kept the CPU waiting count toward the cap.
            if (cpu_pend_at_grant) begin
              if (burst_cnt != BURST_SAT) begin
                burst_cnt <= burst_cnt + 1'b1;
              end
            end else begin
              burst_cnt <= '0;
            end
          end
          CPU_RET: begin
            if (!cpu_we_q) begin
              cpu_rdata <= mem_rdata;
            end
            cpu_ack   <= 1'b1;
            burst_cnt <= '0;
          end
          default: begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end
        endcase
      end
    end
  end

  // Per-frame DMA byte counter.
  // A DMA ack on the same edge as frame_start is counted in the frame that
  // is closing. It also starts the new frame's count at 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt    <= '0;
      frame_bytes <= '0;
    end else if (clk_enable) begin
      if (frame_start) begin
        frame_bytes <= dma_done ? byte_cnt_inc : byte_cnt;
        byte_cnt    <= dma_done ? 11'd1 : 11'd0;
      end else if (dma_done) begin
        byte_cnt <= byte_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_pixie_dma_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pixie_dma_arbiter
//
// Directed bench for pixie_dma_arbiter.
// The RAM behind the arbiter is modelled here: a 64 KiB synchronous RAM with
// 1-clock read latency, plus a side load port for preloading test data.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_pixie_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [1:0]  cpu_sc = 2'b00;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        dma_req = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_data;
  logic        dma_ack;
  logic        frame_start = 1'b0;
  logic [1:0]  sc_out;
  logic [10:0] frame_bytes;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  logic [7:0]  ram [0:65535];
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic [7:0]  load_data = '0;

  int checks = 0;
  int errors = 0;

  pixie_dma_arbiter #(.DMA_BURST_MAX(8), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_sc(cpu_sc), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .dma_req(dma_req), .dma_addr(dma_addr),
    .dma_data(dma_data), .dma_ack(dma_ack), .frame_start(frame_start),
    .sc_out(sc_out), .frame_bytes(frame_bytes), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: a preload write takes precedence over the arbiter's port.
  always @(posedge clk) begin
    if (load_en) begin
      ram[load_addr] <= load_data;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic load_ram(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output bit done);
    done = 1'b0; rd = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (cpu_ack) begin done = 1'b1; rd = cpu_rdata; cpu_req = 1'b0; end
    end
    cpu_req = 1'b0;
  endtask

  task automatic dma_bytes(input int n, output int got);
    got = 0;
    @(negedge clk);
    dma_req = 1'b1; dma_addr = 16'h2000;
    for (int i = 0; i < 4 * n + 20 && got < n; i++) begin
      @(negedge clk);
      if (dma_ack) begin
        got++;
        if (got == n) dma_req = 1'b0;
        else          dma_addr = dma_addr + 16'd1;
      end
    end
    dma_req = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_sc = 2'b11;
    repeat (3) @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en: got %b expected 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if ({cpu_ack, dma_ack} !== 2'b00) begin errors++; $display("[TB] FAIL reset_acks: got %b expected 00", {cpu_ack, dma_ack}); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    checks++; if ({cpu_rdata, dma_data} !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0000", {cpu_rdata, dma_data}); end
    checks++; if (frame_bytes !== 11'd0) begin errors++; $display("[TB] FAIL reset_frame_bytes: got %0d expected 0", frame_bytes); end
    checks++; if (sc_out !== 2'b11) begin errors++; $display("[TB] FAIL reset_sc_out: got %b expected 11", sc_out); end
    reset = 1'b1; cpu_sc = 2'b00;
  endtask

  task automatic test_cpu_read();
    int en_cycles = 0;
    int ack_at = -1;
    int acks = 0;
    int sc_dma = 0;
    logic [7:0] rd = '0;
    load_ram(16'h0123, 8'h5A);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123; cpu_sc = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cycles++;
        checks++; if ({mem_we, mem_addr} !== 17'h00123) begin errors++; $display("[TB] FAIL cpu_read_mem_port: got we=%b addr=%h expected we=0 addr=0123", mem_we, mem_addr); end
      end
      if (sc_out == 2'b10) sc_dma++;
      if (cpu_ack) begin
        acks++;
        if (ack_at < 0) begin ack_at = i; rd = cpu_rdata; end
        cpu_req = 1'b0;
      end
    end
    checks++; if (en_cycles !== 1) begin errors++; $display("[TB] FAIL cpu_read_mem_en_cycles: got %0d expected 1", en_cycles); end
    checks++; if (ack_at !== 2) begin errors++; $display("[TB] FAIL cpu_read_ack_latency: got %0d expected 2", ack_at); end
    checks++; if (acks !== 1) begin errors++; $display("[TB] FAIL cpu_read_ack_count: got %0d expected 1", acks); end
    checks++; if (rd !== 8'h5A) begin errors++; $display("[TB] FAIL cpu_read_data: got %h expected 5a", rd); end
    checks++; if (sc_dma !== 0) begin errors++; $display("[TB] FAIL cpu_read_sc_out: got %0d S2 cycles expected 0", sc_dma); end
  endtask

  task automatic test_cpu_write();
    logic [7:0] rd;
    bit done;
    cpu_access(1'b1, 16'h0200, 8'hA5, rd, done);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL cpu_write_ack: got %b expected 1", done); end
    checks++; if (ram[16'h0200] !== 8'hA5) begin errors++; $display("[TB] FAIL cpu_write_ram: got %h expected a5", ram[16'h0200]); end
    cpu_access(1'b0, 16'h0200, 8'h00, rd, done);
    checks++; if (rd !== 8'hA5) begin errors++; $display("[TB] FAIL cpu_write_readback: got %h expected a5", rd); end
  endtask

  task automatic test_pixie_line();
    int n = 0;
    int sc_dma = 0;
    int en_cycles = 0;
    for (int i = 0; i < 8; i++) load_ram(16'h0900 + 16'(i), 8'hC0 + 8'(i));
    cpu_sc = 2'b01;
    @(negedge clk);
    dma_req = 1'b1; dma_addr = 16'h0900;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sc_out == 2'b10) sc_dma++;
      else begin
        checks++; if (sc_out !== 2'b01) begin errors++; $display("[TB] FAIL pixie_sc_cpu: got %b expected 01", sc_out); end
      end
      if (mem_en) en_cycles++;
      if (dma_ack) begin
        checks++; if (dma_data !== 8'hC0 + 8'(n)) begin errors++; $display("[TB] FAIL pixie_data%0d: got %h expected %h", n, dma_data, 8'hC0 + 8'(n)); end
        n++;
        if (n == 8) dma_req = 1'b0;
        else        dma_addr = dma_addr + 16'd1;
      end
    end
    checks++; if (n !== 8) begin errors++; $display("[TB] FAIL pixie_ack_count: got %0d expected 8", n); end
    checks++; if (sc_dma !== 16) begin errors++; $display("[TB] FAIL pixie_sc_s2_cycles: got %0d expected 16", sc_dma); end
    checks++; if (en_cycles !== 8) begin errors++; $display("[TB] FAIL pixie_mem_en_cycles: got %0d expected 8", en_cycles); end
    cpu_sc = 2'b00;
  endtask

  task automatic test_burst_cap();
    string seq = "";
    int dma_left = 20;
    int cpu_left = 3;
    @(negedge clk);
    dma_req = 1'b1; dma_addr = 16'h1000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123;
    for (int i = 0; i < 400 && (dma_left > 0 || cpu_left > 0); i++) begin
      @(negedge clk);
      if (dma_ack) begin
        seq = {seq, "D"}; dma_left--;
        if (dma_left == 0) dma_req = 1'b0;
        else               dma_addr = dma_addr + 16'd1;
      end
      if (cpu_ack) begin
        seq = {seq, "C"}; cpu_left--;
        if (cpu_left == 0) cpu_req = 1'b0;
      end
    end
    dma_req = 1'b0; cpu_req = 1'b0;
    checks++; if (seq != "DDDDDDDDCDDDDDDDDCDDDDC") begin errors++; $display("[TB] FAIL burst_cap_order: got %s expected DDDDDDDDCDDDDDDDDCDDDDC", seq); end
  endtask

  task automatic run_pair(input bit stretch, output string seq, output int cyc,
                          output logic [7:0] drd, output logic [7:0] crd);
    bit dma_open = 1'b1;
    bit cpu_open = 1'b1;
    seq = ""; cyc = -1; drd = '0; crd = '0;
    @(negedge clk);
    clk_enable = 1'b1;
    dma_req = 1'b1; dma_addr = 16'h0900;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123;
    for (int i = 0; i < 60 && (dma_open || cpu_open); i++) begin
      @(negedge clk);
      clk_enable = stretch ? ((i + 1) % 2 == 0) : 1'b1;
      if (dma_ack) begin seq = {seq, "D"}; drd = dma_data; dma_req = 1'b0; dma_open = 1'b0; end
      if (cpu_ack) begin seq = {seq, "C"}; crd = cpu_rdata; cpu_req = 1'b0; cpu_open = 1'b0; cyc = i + 1; end
    end
    clk_enable = 1'b1; dma_req = 1'b0; cpu_req = 1'b0;
  endtask

  task automatic test_simultaneous_stretch();
    string seq;
    int cyc;
    logic [7:0] drd, crd;
    run_pair(1'b0, seq, cyc, drd, crd);
    checks++; if (seq != "DC") begin errors++; $display("[TB] FAIL simul_order: got %s expected DC", seq); end
    checks++; if (cyc !== 6) begin errors++; $display("[TB] FAIL simul_cycles: got %0d expected 6", cyc); end
    checks++; if ({drd, crd} !== 16'hC05A) begin errors++; $display("[TB] FAIL simul_data: got %h expected c05a", {drd, crd}); end
    run_pair(1'b1, seq, cyc, drd, crd);
    checks++; if (seq != "DC") begin errors++; $display("[TB] FAIL stretch_order: got %s expected DC", seq); end
    checks++; if (cyc !== 11) begin errors++; $display("[TB] FAIL stretch_cycles: got %0d expected 11", cyc); end
    checks++; if ({drd, crd} !== 16'hC05A) begin errors++; $display("[TB] FAIL stretch_data: got %h expected c05a", {drd, crd}); end
  endtask

  task automatic test_frame_count();
    int got;
    // Bytes so far since reset: 8 (line) + 20 (burst) + 2 (one per pair run).
    pulse_frame();
    checks++; if (frame_bytes !== 11'd30) begin errors++; $display("[TB] FAIL frame_prior: got %0d expected 30", frame_bytes); end
    dma_bytes(1024, got);
    checks++; if (got !== 1024) begin errors++; $display("[TB] FAIL frame_1024_acks: got %0d expected 1024", got); end
    pulse_frame();
    checks++; if (frame_bytes !== 11'd1024) begin errors++; $display("[TB] FAIL frame_1024: got %0d expected 1024", frame_bytes); end
    // A sixth byte whose ack edge coincides with frame_start.
    dma_bytes(5, got);
    @(negedge clk);
    dma_req = 1'b1; dma_addr = 16'h3000;
    @(negedge clk);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checks++; if (dma_ack !== 1'b1) begin errors++; $display("[TB] FAIL frame_coincident_ack: got %b expected 1", dma_ack); end
    dma_req = 1'b0;
    checks++; if (frame_bytes !== 11'd6) begin errors++; $display("[TB] FAIL frame_coincident: got %0d expected 6", frame_bytes); end
    pulse_frame();
    checks++; if (frame_bytes !== 11'd1) begin errors++; $display("[TB] FAIL frame_carry: got %0d expected 1", frame_bytes); end
    dma_bytes(2050, got);
    pulse_frame();
    checks++; if (frame_bytes !== 11'd2047) begin errors++; $display("[TB] FAIL frame_saturate: got %0d expected 2047", frame_bytes); end
  endtask

  task automatic test_reset_mid_dma();
    int acks = 0;
    cpu_sc = 2'b01;
    @(negedge clk);
    dma_req = 1'b1; dma_addr = 16'h0900;
    @(negedge clk);
    checks++; if ({mem_en, sc_out} !== 3'b110) begin errors++; $display("[TB] FAIL midreset_in_acc: got en=%b sc=%b expected en=1 sc=10", mem_en, sc_out); end
    reset = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if ({mem_en, sc_out} !== 3'b001) begin errors++; $display("[TB] FAIL midreset_idle: got en=%b sc=%b expected en=0 sc=01", mem_en, sc_out); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dma_ack) acks++;
      checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL midreset_mem_en: got %b expected 0", mem_en); end
    end
    checks++; if (acks !== 0) begin errors++; $display("[TB] FAIL midreset_no_ack: got %0d acks expected 0", acks); end
    checks++; if (frame_bytes !== 11'd0) begin errors++; $display("[TB] FAIL midreset_frame_bytes: got %0d expected 0", frame_bytes); end
  endtask

  initial begin
    $display("[TB] pixie_dma_arbiter bench start");
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_pixie_line();
    test_burst_cap();
    test_simultaneous_stretch();
    test_frame_count();
    test_reset_mid_dma();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
